// File: rtl/fifo_nibble_packer.sv
// Packs pairs of nibbles read from a first-word-fall-through FIFO into bytes
// behind a valid/ready output, with flush support for a trailing half byte.
module fifo_nibble_packer #(
  parameter int NIBBLE_WIDTH = 4,
  parameter bit LOW_FIRST    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fifo_empty,
  input  logic [NIBBLE_WIDTH-1:0]   fifo_data,
  output logic                      fifo_pop,
  input  logic                      enable,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*NIBBLE_WIDTH-1:0] out_data,
  output logic                      out_partial,
  output logic                      out_parity,
  output logic [7:0]                byte_count
);

  localparam int BW = 2 * NIBBLE_WIDTH;

  typedef enum logic [1:0] {
    NEED_LO = 2'd0,
    NEED_HI = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [NIBBLE_WIDTH-1:0] nib_reg, nib_next;
  logic [BW-1:0]           data_reg, data_next;
  logic                    partial_reg, partial_next;
  logic                    parity_reg, parity_next;
  logic [7:0]              count_reg, count_next;
  logic                    armed_reg;

  logic [BW-1:0] pair_byte;
  logic [BW-1:0] flush_byte;

  // The first popped nibble lands in the low or high half depending on LOW_FIRST.
  generate
    if (LOW_FIRST) begin : g_low_first
      assign pair_byte  = {fifo_data, nib_reg};
      assign flush_byte = {{NIBBLE_WIDTH{1'b0}}, nib_reg};
    end else begin : g_high_first
      assign pair_byte  = {nib_reg, fifo_data};
      assign flush_byte = {nib_reg, {NIBBLE_WIDTH{1'b0}}};
    end
  endgenerate

  // armed_reg blocks popping on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= NEED_LO;
      nib_reg     <= '0;
      data_reg    <= '0;
      partial_reg <= 1'b0;
      parity_reg  <= 1'b0;
      count_reg   <= 8'd0;
      armed_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      nib_reg     <= nib_next;
      data_reg    <= data_next;
      partial_reg <= partial_next;
      parity_reg  <= parity_next;
      count_reg   <= count_next;
      armed_reg   <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    nib_next     = nib_reg;
    data_next    = data_reg;
    partial_next = partial_reg;
    parity_next  = parity_reg;
    count_next   = count_reg;
    fifo_pop     = 1'b0;

    case (state_reg)
      NEED_LO: begin
        if (armed_reg && enable && !fifo_empty) begin
          fifo_pop   = 1'b1;
          nib_next   = fifo_data;
          state_next = NEED_HI;
        end
      end
      NEED_HI: begin
        if (armed_reg && enable) begin
          if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            data_next    = pair_byte;
            partial_next = 1'b0;
            parity_next  = ^pair_byte;
            state_next   = HOLD;
          end else if (flush) begin
            data_next    = flush_byte;
            partial_next = 1'b1;
            parity_next  = ^flush_byte;
            state_next   = HOLD;
          end
        end
      end
      HOLD: begin
        // Acceptance is a pure handshake and ignores enable.
        if (out_ready) begin
          count_next = count_reg + 8'd1;
          state_next = NEED_LO;
        end
      end
      default: begin
        state_next = NEED_LO;
      end
    endcase
  end

  assign out_valid   = (state_reg == HOLD);
  assign out_data    = data_reg;
  assign out_partial = partial_reg;
  assign out_parity  = parity_reg;
  assign byte_count  = count_reg;

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Self-checking bench: two packers (low-first and high-first) fed by one FIFO model.
module tb_fifo_nibble_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fifo_empty;
  logic [3:0] fifo_data;
  logic       enable;
  logic       flush;
  logic       out_ready;

  logic       lo_pop, lo_valid, lo_partial, lo_parity;
  logic [7:0] lo_data, lo_count;
  logic       hi_pop, hi_valid, hi_partial, hi_parity;
  logic [7:0] hi_data, hi_count;

  int tests = 0;
  int failures = 0;

  logic [3:0] fq[$];
  logic [3:0] pn[$];
  logic [7:0] model_count = 8'd0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp_lo;
    logic [7:0] exp_hi;
    logic       exp_par;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  fifo_nibble_packer #(.NIBBLE_WIDTH(4), .LOW_FIRST(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(lo_pop), .enable(enable), .flush(flush), .out_valid(lo_valid),
    .out_ready(out_ready), .out_data(lo_data), .out_partial(lo_partial),
    .out_parity(lo_parity), .byte_count(lo_count)
  );

  fifo_nibble_packer #(.NIBBLE_WIDTH(4), .LOW_FIRST(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(hi_pop), .enable(enable), .flush(flush), .out_valid(hi_valid),
    .out_ready(out_ready), .out_data(hi_data), .out_partial(hi_partial),
    .out_parity(hi_parity), .byte_count(hi_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? 4'h0 : fq[0];
  endtask

  // One clock: sample the pop request, let the FIFO model respond at the edge.
  task automatic tick();
    logic p;
    #1;
    p = lo_pop;
    @(posedge clk);
    if (p && fq.size() > 0) pn.push_back(fq.pop_front());
    #1;
    set_fifo();
  endtask

  task automatic run_pair(input logic [3:0] a, input logic [3:0] b, input logic [7:0] el,
                          input logic [7:0] eh, input logic ep, input string name);
    int pops;
    int cyc;
    enable = 1'b1; flush = 1'b0; out_ready = 1'b1;
    fq.push_back(a); fq.push_back(b); set_fifo();
    pops = 0; cyc = 0;
    while (cyc < 20) begin
      #1;
      if (lo_valid) break;
      if (lo_pop) pops++;
      tick();
      cyc++;
    end
    if (!lo_valid) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_pops"}, pops, 2);
      chk({name, "_cycles"}, cyc, 2);
      chk({name, "_lo_data"}, lo_data, el);
      chk({name, "_hi_data"}, hi_data, eh);
      chk({name, "_lo_par"}, lo_parity, ep);
      chk({name, "_hi_par"}, hi_parity, ep);
      chk({name, "_partial"}, lo_partial, 1'b0);
      tick();
      model_count = model_count + 8'd1;
      #1;
      chk({name, "_count"}, lo_count, model_count);
      chk({name, "_valid_drop"}, lo_valid, 1'b0);
    end
    $display("[TB] pair %s a=%0h b=%0h lo=%02h hi=%02h count=%0d", name, a, b, lo_data, hi_data, lo_count);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic       exp_valid, exp_pop, acc;
    logic [3:0] ra, rb;

    vecs[0] = '{4'h3, 4'hA, 8'hA3, 8'h3A, 1'b0};
    vecs[1] = '{4'h0, 4'h0, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{4'hF, 4'h1, 8'h1F, 8'hF1, 1'b1};
    vecs[3] = '{4'h5, 4'hC, 8'hC5, 8'h5C, 1'b0};
    vecs[4] = '{4'h7, 4'h8, 8'h87, 8'h78, 1'b0};
    vecs[5] = '{4'hE, 4'h0, 8'h0E, 8'hE0, 1'b1};

    // Reset with a non-empty FIFO and enable high.
    rst_n = 1'b0; enable = 1'b1; flush = 1'b0; out_ready = 1'b0;
    fq.push_back(4'h9); set_fifo();
    tick(); tick();
    chk("rst_pop", lo_pop, 1'b0);
    chk("rst_valid", lo_valid, 1'b0);
    chk("rst_data", lo_data, 8'h00);
    chk("rst_partial", lo_partial, 1'b0);
    chk("rst_parity", lo_parity, 1'b0);
    chk("rst_count", lo_count, 8'h00);
    $display("[TB] reset state checked");

    rst_n = 1'b1;
    #1;
    chk("release_edge_no_pop", lo_pop, 1'b0);
    tick();
    #1;
    chk("first_pop_after_release", lo_pop, 1'b1);
    tick();
    #1;
    chk("need_hi_not_valid", lo_valid, 1'b0);

    // Reset asserted while one nibble is held.
    rst_n = 1'b0;
    #1;
    chk("midrst_pop", lo_pop, 1'b0);
    chk("midrst_valid", lo_valid, 1'b0);
    chk("midrst_data", lo_data, 8'h00);
    chk("midrst_count", lo_count, 8'h00);
    fq.delete(); set_fifo();
    tick();
    rst_n = 1'b1;
    tick();
    pn.delete();
    run_pair(4'h1, 4'h2, 8'h21, 8'h12, 1'b0, "post_reset");

    for (int i = 0; i < 6; i++)
      run_pair(vecs[i].a, vecs[i].b, vecs[i].exp_lo, vecs[i].exp_hi, vecs[i].exp_par, $sformatf("vec%0d", i));

    // Half byte: no flush means no output; flush closes it with a zero nibble.
    enable = 1'b1; out_ready = 1'b1; flush = 1'b0;
    fq.push_back(4'h5); set_fifo();
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("noflush_valid", lo_valid, 1'b0);
      tick();
    end
    flush = 1'b1;
    tick();
    #1;
    chk("flush_valid", lo_valid, 1'b1);
    chk("flush_lo_data", lo_data, 8'h05);
    chk("flush_hi_data", hi_data, 8'h50);
    chk("flush_lo_partial", lo_partial, 1'b1);
    chk("flush_hi_partial", hi_partial, 1'b1);
    chk("flush_parity", lo_parity, 1'b0);
    $display("[TB] flush lo=%02h hi=%02h partial=%0b", lo_data, hi_data, lo_partial);
    tick();
    model_count = model_count + 8'd1;
    #1;
    chk("flush_count", lo_count, model_count);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("flush_need_lo_valid", lo_valid, 1'b0);
      tick();
    end
    flush = 1'b0;

    // Backpressure: byte held with FIFO non-empty.
    out_ready = 1'b0;
    fq.push_back(4'h4); fq.push_back(4'h6); fq.push_back(4'h7); fq.push_back(4'h7); set_fifo();
    for (int i = 0; i < 20; i++) begin
      #1;
      if (lo_valid) break;
      tick();
    end
    chk("hold_valid", lo_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("hold_pop", lo_pop, 1'b0);
      chk("hold_data", lo_data, 8'h64);
      chk("hold_valid_stable", lo_valid, 1'b1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    model_count = model_count + 8'd1;
    #1;
    chk("pulse_count", lo_count, model_count);
    chk("pulse_valid_drop", lo_valid, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    #1;
    chk("single_accept_count", lo_count, model_count);
    chk("second_byte_data", lo_data, 8'h77);
    chk("second_byte_valid", lo_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    model_count = model_count + 8'd1;
    #1;
    chk("second_accept_count", lo_count, model_count);
    $display("[TB] backpressure count=%0d", lo_count);

    // 256 bytes at full rate: counter wraps back to its starting value.
    for (int i = 0; i < 256; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      run_pair(ra, rb, {rb, ra}, {ra, rb}, ^{ra, rb}, "wrap");
    end
    chk("wrap_count", lo_count, model_count);

    // Random traffic against a nibble-accounting model.
    pn.delete();
    for (int i = 0; i < 600; i++) begin
      if (fq.size() < 6 && $urandom_range(0, 1) == 1) fq.push_back(4'($urandom_range(0, 15)));
      set_fifo();
      enable = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) == 1);
      flush = 1'b0;
      #1;
      exp_valid = (pn.size() == 2);
      exp_pop = enable && !fifo_empty && (pn.size() < 2);
      chk("rnd_valid", lo_valid, exp_valid);
      chk("rnd_lo_pop", lo_pop, exp_pop);
      chk("rnd_hi_pop", hi_pop, exp_pop);
      if (exp_valid) begin
        chk("rnd_lo_data", lo_data, {pn[1], pn[0]});
        chk("rnd_hi_data", hi_data, {pn[0], pn[1]});
        chk("rnd_parity", lo_parity, ^{pn[1], pn[0]});
        chk("rnd_partial", lo_partial, 1'b0);
      end
      acc = exp_valid && out_ready;
      tick();
      if (acc) begin
        if (pn.size() > 0) void'(pn.pop_front());
        if (pn.size() > 0) void'(pn.pop_front());
        model_count = model_count + 8'd1;
        $display("[TB] rnd accept #%0d count=%0d", i, lo_count);
      end
      chk("rnd_count", lo_count, model_count);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
